// File: rtl/axi_mem_slice.sv
// AXI4 five-channel register slice: every channel passes through a 2-entry skid buffer
// so no valid, ready or payload path crosses combinationally between the two sides.

module axi_mem_slice_buf #(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] entry_q [2];
    logic [DATA_W-1:0] entry_d [2];
    logic              push, pop;

    always_comb begin
        push        = in_valid & in_ready_q;
        pop         = out_valid_q & out_ready;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        entry_d     = entry_q;
        if (push) begin
            entry_d[wr_ptr_q] = in_data;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        // Handshake flags are precomputed from the next count so both are plain flops.
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = entry_q[rd_ptr_q];
endmodule

module axi_mem_slice #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        test_en_i,
    input  logic                        slave_aw_valid,
    output logic                        slave_aw_ready,
    input  logic [AXI_ID_WIDTH-1:0]     slave_aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   slave_aw_addr,
    input  logic [7:0]                  slave_aw_len,
    input  logic [2:0]                  slave_aw_size,
    input  logic [1:0]                  slave_aw_burst,
    input  logic                        slave_aw_lock,
    input  logic [3:0]                  slave_aw_cache,
    input  logic [2:0]                  slave_aw_prot,
    input  logic [3:0]                  slave_aw_region,
    input  logic [3:0]                  slave_aw_qos,
    input  logic [AXI_USER_WIDTH-1:0]   slave_aw_user,
    input  logic                        slave_w_valid,
    output logic                        slave_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   slave_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] slave_w_strb,
    input  logic                        slave_w_last,
    input  logic [AXI_USER_WIDTH-1:0]   slave_w_user,
    output logic                        slave_b_valid,
    input  logic                        slave_b_ready,
    output logic [AXI_ID_WIDTH-1:0]     slave_b_id,
    output logic [1:0]                  slave_b_resp,
    output logic [AXI_USER_WIDTH-1:0]   slave_b_user,
    input  logic                        slave_ar_valid,
    output logic                        slave_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]     slave_ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   slave_ar_addr,
    input  logic [7:0]                  slave_ar_len,
    input  logic [2:0]                  slave_ar_size,
    input  logic [1:0]                  slave_ar_burst,
    input  logic                        slave_ar_lock,
    input  logic [3:0]                  slave_ar_cache,
    input  logic [2:0]                  slave_ar_prot,
    input  logic [3:0]                  slave_ar_region,
    input  logic [3:0]                  slave_ar_qos,
    input  logic [AXI_USER_WIDTH-1:0]   slave_ar_user,
    output logic                        slave_r_valid,
    input  logic                        slave_r_ready,
    output logic [AXI_ID_WIDTH-1:0]     slave_r_id,
    output logic [AXI_DATA_WIDTH-1:0]   slave_r_data,
    output logic [1:0]                  slave_r_resp,
    output logic                        slave_r_last,
    output logic [AXI_USER_WIDTH-1:0]   slave_r_user,
    output logic                        master_aw_valid,
    input  logic                        master_aw_ready,
    output logic [AXI_ID_WIDTH-1:0]     master_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]   master_aw_addr,
    output logic [7:0]                  master_aw_len,
    output logic [2:0]                  master_aw_size,
    output logic [1:0]                  master_aw_burst,
    output logic                        master_aw_lock,
    output logic [3:0]                  master_aw_cache,
    output logic [2:0]                  master_aw_prot,
    output logic [3:0]                  master_aw_region,
    output logic [3:0]                  master_aw_qos,
    output logic [AXI_USER_WIDTH-1:0]   master_aw_user,
    output logic                        master_w_valid,
    input  logic                        master_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   master_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] master_w_strb,
    output logic                        master_w_last,
    output logic [AXI_USER_WIDTH-1:0]   master_w_user,
    input  logic                        master_b_valid,
    output logic                        master_b_ready,
    input  logic [AXI_ID_WIDTH-1:0]     master_b_id,
    input  logic [1:0]                  master_b_resp,
    input  logic [AXI_USER_WIDTH-1:0]   master_b_user,
    output logic                        master_ar_valid,
    input  logic                        master_ar_ready,
    output logic [AXI_ID_WIDTH-1:0]     master_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]   master_ar_addr,
    output logic [7:0]                  master_ar_len,
    output logic [2:0]                  master_ar_size,
    output logic [1:0]                  master_ar_burst,
    output logic                        master_ar_lock,
    output logic [3:0]                  master_ar_cache,
    output logic [2:0]                  master_ar_prot,
    output logic [3:0]                  master_ar_region,
    output logic [3:0]                  master_ar_qos,
    output logic [AXI_USER_WIDTH-1:0]   master_ar_user,
    input  logic                        master_r_valid,
    output logic                        master_r_ready,
    input  logic [AXI_ID_WIDTH-1:0]     master_r_id,
    input  logic [AXI_DATA_WIDTH-1:0]   master_r_data,
    input  logic [1:0]                  master_r_resp,
    input  logic                        master_r_last,
    input  logic [AXI_USER_WIDTH-1:0]   master_r_user
);
    localparam int unsigned AX_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH;
    localparam int unsigned W_W  = AXI_DATA_WIDTH + AXI_DATA_WIDTH/8 + 1 + AXI_USER_WIDTH;
    localparam int unsigned B_W  = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
    localparam int unsigned R_W  = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3 + AXI_USER_WIDTH;

    logic [AX_W-1:0] aw_out, ar_out;
    logic [W_W-1:0]  w_out;
    logic [B_W-1:0]  b_out;
    logic [R_W-1:0]  r_out;
    logic            unused_test_en;

    assign unused_test_en = test_en_i;

    axi_mem_slice_buf #(.DATA_W(AX_W)) u_aw (
        .clk, .rst_n,
        .in_valid (slave_aw_valid), .in_ready (slave_aw_ready),
        .in_data  ({slave_aw_id, slave_aw_addr, slave_aw_len, slave_aw_size, slave_aw_burst,
                    slave_aw_lock, slave_aw_cache, slave_aw_prot, slave_aw_region,
                    slave_aw_qos, slave_aw_user}),
        .out_valid(master_aw_valid), .out_ready(master_aw_ready), .out_data(aw_out)
    );
    assign {master_aw_id, master_aw_addr, master_aw_len, master_aw_size, master_aw_burst,
            master_aw_lock, master_aw_cache, master_aw_prot, master_aw_region,
            master_aw_qos, master_aw_user} = aw_out;

    axi_mem_slice_buf #(.DATA_W(W_W)) u_w (
        .clk, .rst_n,
        .in_valid (slave_w_valid), .in_ready (slave_w_ready),
        .in_data  ({slave_w_data, slave_w_strb, slave_w_last, slave_w_user}),
        .out_valid(master_w_valid), .out_ready(master_w_ready), .out_data(w_out)
    );
    assign {master_w_data, master_w_strb, master_w_last, master_w_user} = w_out;

    axi_mem_slice_buf #(.DATA_W(B_W)) u_b (
        .clk, .rst_n,
        .in_valid (master_b_valid), .in_ready (master_b_ready),
        .in_data  ({master_b_id, master_b_resp, master_b_user}),
        .out_valid(slave_b_valid), .out_ready(slave_b_ready), .out_data(b_out)
    );
    assign {slave_b_id, slave_b_resp, slave_b_user} = b_out;

    axi_mem_slice_buf #(.DATA_W(AX_W)) u_ar (
        .clk, .rst_n,
        .in_valid (slave_ar_valid), .in_ready (slave_ar_ready),
        .in_data  ({slave_ar_id, slave_ar_addr, slave_ar_len, slave_ar_size, slave_ar_burst,
                    slave_ar_lock, slave_ar_cache, slave_ar_prot, slave_ar_region,
                    slave_ar_qos, slave_ar_user}),
        .out_valid(master_ar_valid), .out_ready(master_ar_ready), .out_data(ar_out)
    );
    assign {master_ar_id, master_ar_addr, master_ar_len, master_ar_size, master_ar_burst,
            master_ar_lock, master_ar_cache, master_ar_prot, master_ar_region,
            master_ar_qos, master_ar_user} = ar_out;

    axi_mem_slice_buf #(.DATA_W(R_W)) u_r (
        .clk, .rst_n,
        .in_valid (master_r_valid), .in_ready (master_r_ready),
        .in_data  ({master_r_id, master_r_data, master_r_resp, master_r_last, master_r_user}),
        .out_valid(slave_r_valid), .out_ready(slave_r_ready), .out_data(r_out)
    );
    assign {slave_r_id, slave_r_data, slave_r_resp, slave_r_last, slave_r_user} = r_out;
endmodule

// File: tb/tb_axi_mem_slice.sv
// Self-checking bench for axi_mem_slice: directed table, hand-written corner sequences and
// a randomized W/R run checked against a queue-based channel model.

module tb_axi_mem_slice;
    logic clk = 1'b0;
    logic rst_n, test_en_i;
    always #5 clk = ~clk;

    logic        slave_aw_valid, slave_aw_ready, slave_aw_lock;
    logic [9:0]  slave_aw_id, slave_aw_user;
    logic [31:0] slave_aw_addr;
    logic [7:0]  slave_aw_len;
    logic [2:0]  slave_aw_size, slave_aw_prot;
    logic [1:0]  slave_aw_burst;
    logic [3:0]  slave_aw_cache, slave_aw_region, slave_aw_qos;
    logic        slave_w_valid, slave_w_ready, slave_w_last;
    logic [63:0] slave_w_data;
    logic [7:0]  slave_w_strb;
    logic [9:0]  slave_w_user;
    logic        slave_b_valid, slave_b_ready;
    logic [9:0]  slave_b_id, slave_b_user;
    logic [1:0]  slave_b_resp;
    logic        slave_ar_valid, slave_ar_ready, slave_ar_lock;
    logic [9:0]  slave_ar_id, slave_ar_user;
    logic [31:0] slave_ar_addr;
    logic [7:0]  slave_ar_len;
    logic [2:0]  slave_ar_size, slave_ar_prot;
    logic [1:0]  slave_ar_burst;
    logic [3:0]  slave_ar_cache, slave_ar_region, slave_ar_qos;
    logic        slave_r_valid, slave_r_ready, slave_r_last;
    logic [9:0]  slave_r_id, slave_r_user;
    logic [63:0] slave_r_data;
    logic [1:0]  slave_r_resp;
    logic        master_aw_valid, master_aw_ready, master_aw_lock;
    logic [9:0]  master_aw_id, master_aw_user;
    logic [31:0] master_aw_addr;
    logic [7:0]  master_aw_len;
    logic [2:0]  master_aw_size, master_aw_prot;
    logic [1:0]  master_aw_burst;
    logic [3:0]  master_aw_cache, master_aw_region, master_aw_qos;
    logic        master_w_valid, master_w_ready, master_w_last;
    logic [63:0] master_w_data;
    logic [7:0]  master_w_strb;
    logic [9:0]  master_w_user;
    logic        master_b_valid, master_b_ready;
    logic [9:0]  master_b_id, master_b_user;
    logic [1:0]  master_b_resp;
    logic        master_ar_valid, master_ar_ready, master_ar_lock;
    logic [9:0]  master_ar_id, master_ar_user;
    logic [31:0] master_ar_addr;
    logic [7:0]  master_ar_len;
    logic [2:0]  master_ar_size, master_ar_prot;
    logic [1:0]  master_ar_burst;
    logic [3:0]  master_ar_cache, master_ar_region, master_ar_qos;
    logic        master_r_valid, master_r_ready, master_r_last;
    logic [9:0]  master_r_id, master_r_user;
    logic [63:0] master_r_data;
    logic [1:0]  master_r_resp;

    logic [80:0] aw_drv, ar_drv, aw_out, ar_out;
    logic [82:0] w_drv, w_out;
    logic [21:0] b_drv, b_out;
    logic [86:0] r_drv, r_out;

    assign {slave_aw_id, slave_aw_addr, slave_aw_len, slave_aw_size, slave_aw_burst, slave_aw_lock,
            slave_aw_cache, slave_aw_prot, slave_aw_region, slave_aw_qos, slave_aw_user} = aw_drv;
    assign {slave_ar_id, slave_ar_addr, slave_ar_len, slave_ar_size, slave_ar_burst, slave_ar_lock,
            slave_ar_cache, slave_ar_prot, slave_ar_region, slave_ar_qos, slave_ar_user} = ar_drv;
    assign {slave_w_data, slave_w_strb, slave_w_last, slave_w_user} = w_drv;
    assign {master_b_id, master_b_resp, master_b_user} = b_drv;
    assign {master_r_id, master_r_data, master_r_resp, master_r_last, master_r_user} = r_drv;
    assign aw_out = {master_aw_id, master_aw_addr, master_aw_len, master_aw_size, master_aw_burst,
                     master_aw_lock, master_aw_cache, master_aw_prot, master_aw_region,
                     master_aw_qos, master_aw_user};
    assign ar_out = {master_ar_id, master_ar_addr, master_ar_len, master_ar_size, master_ar_burst,
                     master_ar_lock, master_ar_cache, master_ar_prot, master_ar_region,
                     master_ar_qos, master_ar_user};
    assign w_out = {master_w_data, master_w_strb, master_w_last, master_w_user};
    assign b_out = {slave_b_id, slave_b_resp, slave_b_user};
    assign r_out = {slave_r_id, slave_r_data, slave_r_resp, slave_r_last, slave_r_user};

    axi_mem_slice #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
        .slave_aw_valid(slave_aw_valid), .slave_aw_ready(slave_aw_ready), .slave_aw_id(slave_aw_id),
        .slave_aw_addr(slave_aw_addr), .slave_aw_len(slave_aw_len), .slave_aw_size(slave_aw_size),
        .slave_aw_burst(slave_aw_burst), .slave_aw_lock(slave_aw_lock), .slave_aw_cache(slave_aw_cache),
        .slave_aw_prot(slave_aw_prot), .slave_aw_region(slave_aw_region), .slave_aw_qos(slave_aw_qos),
        .slave_aw_user(slave_aw_user),
        .slave_w_valid(slave_w_valid), .slave_w_ready(slave_w_ready), .slave_w_data(slave_w_data),
        .slave_w_strb(slave_w_strb), .slave_w_last(slave_w_last), .slave_w_user(slave_w_user),
        .slave_b_valid(slave_b_valid), .slave_b_ready(slave_b_ready), .slave_b_id(slave_b_id),
        .slave_b_resp(slave_b_resp), .slave_b_user(slave_b_user),
        .slave_ar_valid(slave_ar_valid), .slave_ar_ready(slave_ar_ready), .slave_ar_id(slave_ar_id),
        .slave_ar_addr(slave_ar_addr), .slave_ar_len(slave_ar_len), .slave_ar_size(slave_ar_size),
        .slave_ar_burst(slave_ar_burst), .slave_ar_lock(slave_ar_lock), .slave_ar_cache(slave_ar_cache),
        .slave_ar_prot(slave_ar_prot), .slave_ar_region(slave_ar_region), .slave_ar_qos(slave_ar_qos),
        .slave_ar_user(slave_ar_user),
        .slave_r_valid(slave_r_valid), .slave_r_ready(slave_r_ready), .slave_r_id(slave_r_id),
        .slave_r_data(slave_r_data), .slave_r_resp(slave_r_resp), .slave_r_last(slave_r_last),
        .slave_r_user(slave_r_user),
        .master_aw_valid(master_aw_valid), .master_aw_ready(master_aw_ready), .master_aw_id(master_aw_id),
        .master_aw_addr(master_aw_addr), .master_aw_len(master_aw_len), .master_aw_size(master_aw_size),
        .master_aw_burst(master_aw_burst), .master_aw_lock(master_aw_lock), .master_aw_cache(master_aw_cache),
        .master_aw_prot(master_aw_prot), .master_aw_region(master_aw_region), .master_aw_qos(master_aw_qos),
        .master_aw_user(master_aw_user),
        .master_w_valid(master_w_valid), .master_w_ready(master_w_ready), .master_w_data(master_w_data),
        .master_w_strb(master_w_strb), .master_w_last(master_w_last), .master_w_user(master_w_user),
        .master_b_valid(master_b_valid), .master_b_ready(master_b_ready), .master_b_id(master_b_id),
        .master_b_resp(master_b_resp), .master_b_user(master_b_user),
        .master_ar_valid(master_ar_valid), .master_ar_ready(master_ar_ready), .master_ar_id(master_ar_id),
        .master_ar_addr(master_ar_addr), .master_ar_len(master_ar_len), .master_ar_size(master_ar_size),
        .master_ar_burst(master_ar_burst), .master_ar_lock(master_ar_lock), .master_ar_cache(master_ar_cache),
        .master_ar_prot(master_ar_prot), .master_ar_region(master_ar_region), .master_ar_qos(master_ar_qos),
        .master_ar_user(master_ar_user),
        .master_r_valid(master_r_valid), .master_r_ready(master_r_ready), .master_r_id(master_r_id),
        .master_r_data(master_r_data), .master_r_resp(master_r_resp), .master_r_last(master_r_last),
        .master_r_user(master_r_user)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic        wlast;
        logic [1:0]  bresp;
    } vec_t;

    function automatic logic [80:0] mk_aw(input vec_t v);
        return {v.id, v.addr, v.len, 3'd3, 2'b01, v.id[0], v.id[3:0], v.id[2:0], v.id[7:4], v.id[9:6], ~v.id};
    endfunction
    function automatic logic [80:0] mk_ar(input vec_t v);
        return {~v.id, v.addr + 32'h40, v.len, 3'd2, 2'b10, 1'b0, 4'h3, 3'd5, 4'h1, 4'h2, v.id};
    endfunction

    function automatic logic [86:0] mk_r(input int k);
        return {10'h5, 64'(k), 2'b00, (k == 15), 10'h0};
    endfunction

    // Channel model: a channel holds an ordered list of accepted beats, at most two.
    logic [82:0] wq[$];
    logic [86:0] rq[$];
    bit          w_hs_in, r_hs_in;
    int          w_pops, r_pops, cyc;

    task automatic step(input bit w_off, input logic [82:0] w_pl, input bit w_rdy,
                        input bit r_off, input logic [86:0] r_pl, input bit r_rdy,
                        output bit w_took, output bit r_took);
        @(negedge clk);
        cyc++;
        chk("w_in_ready", slave_w_ready, wq.size() != 2);
        chk("w_out_valid", master_w_valid, wq.size() != 0);
        if (master_w_valid && wq.size() != 0) chk("w_payload", w_out, wq[0]);
        chk("r_in_ready", master_r_ready, rq.size() != 2);
        chk("r_out_valid", slave_r_valid, rq.size() != 0);
        if (slave_r_valid && rq.size() != 0) chk("r_payload", r_out, rq[0]);
        if (w_hs_in) slave_w_valid = 1'b0;
        if (r_hs_in) master_r_valid = 1'b0;
        w_took = 1'b0;
        r_took = 1'b0;
        if (!slave_w_valid && w_off) begin slave_w_valid = 1'b1; w_drv = w_pl; w_took = 1'b1; end
        if (!master_r_valid && r_off) begin master_r_valid = 1'b1; r_drv = r_pl; r_took = 1'b1; end
        master_w_ready = w_rdy;
        slave_r_ready  = r_rdy;
        if (master_w_valid && w_rdy && wq.size() != 0) begin void'(wq.pop_front()); w_pops++; end
        if (slave_r_valid && r_rdy && rq.size() != 0) begin void'(rq.pop_front()); r_pops++; end
        w_hs_in = slave_w_valid && slave_w_ready;
        r_hs_in = master_r_valid && master_r_ready;
        if (w_hs_in) wq.push_back(w_drv);
        if (r_hs_in) rq.push_back(r_drv);
    endtask

    vec_t        tbl[4];
    bit          wt, rt;
    int          k, p0, prev, first_c, last_c;
    logic [95:0] rnd;
    logic [80:0] pa, pb, pc;

    initial begin
        tbl[0] = '{10'd3,   32'h0000_0100, 8'd0,   64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 2'b00};
        tbl[1] = '{10'h3FF, 32'hFFFF_FFFC, 8'hFF,  64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 1'b0, 2'b10};
        tbl[2] = '{10'h000, 32'h0000_0000, 8'h0F,  64'h0,                  8'h00, 1'b1, 2'b11};
        tbl[3] = '{10'h155, 32'hA5A5_5A5A, 8'h80,  64'h0123_4567_89AB_CDEF, 8'hA5, 1'b1, 2'b01};

        rst_n = 1'b0; test_en_i = 1'b0;
        slave_aw_valid = 0; slave_w_valid = 0; slave_ar_valid = 0; master_b_valid = 0; master_r_valid = 0;
        master_aw_ready = 1; master_w_ready = 1; master_ar_ready = 1; slave_b_ready = 1; slave_r_ready = 1;
        aw_drv = '0; ar_drv = '0; w_drv = '0; b_drv = '0; r_drv = '0;
        w_hs_in = 0; r_hs_in = 0; w_pops = 0; r_pops = 0; cyc = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_aw_valid", master_aw_valid, 0);
        chk("rst_w_valid", master_w_valid, 0);
        chk("rst_ar_valid", master_ar_valid, 0);
        chk("rst_b_valid", slave_b_valid, 0);
        chk("rst_r_valid", slave_r_valid, 0);
        chk("rst_readies", {slave_aw_ready, slave_w_ready, slave_ar_ready, master_b_ready, master_r_ready}, 5'h1F);
        @(negedge clk) rst_n = 1'b1;

        // Single-beat transactions on AW/W/AR/B: latency exactly one cycle, payload bit-exact.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            aw_drv = mk_aw(tbl[i]);
            ar_drv = mk_ar(tbl[i]);
            w_drv  = {tbl[i].wdata, tbl[i].strb, tbl[i].wlast, tbl[i].id};
            b_drv  = {tbl[i].id, tbl[i].bresp, ~tbl[i].id};
            slave_aw_valid = 1; slave_ar_valid = 1; slave_w_valid = 1; master_b_valid = 1;
            #1;
            chk("no_bypass", {master_aw_valid, master_w_valid, master_ar_valid, slave_b_valid}, 4'h0);
            @(posedge clk);
            #1;
            chk("tbl_valids", {master_aw_valid, master_w_valid, master_ar_valid, slave_b_valid}, 4'hF);
            chk("tbl_aw", aw_out, mk_aw(tbl[i]));
            chk("tbl_ar", ar_out, mk_ar(tbl[i]));
            chk("tbl_w", w_out, {tbl[i].wdata, tbl[i].strb, tbl[i].wlast, tbl[i].id});
            chk("tbl_b", b_out, {tbl[i].id, tbl[i].bresp, ~tbl[i].id});
            @(negedge clk);
            slave_aw_valid = 0; slave_ar_valid = 0; slave_w_valid = 0; master_b_valid = 0;
            @(posedge clk);
            #1;
            chk("tbl_drained", {master_aw_valid, master_w_valid, master_ar_valid, slave_b_valid}, 4'h0);
        end

        // Streaming R burst of 16 with the slave always ready.
        k = 0; p0 = r_pops; prev = r_pops; first_c = -1; last_c = -1;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, '0, 1'b1, k < 16, mk_r(k), 1'b1, wt, rt);
            if (rt) k++;
            if (r_pops != prev) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                prev = r_pops;
            end
        end
        chk("stream_beats", r_pops - p0, 16);
        chk("stream_no_bubble", last_c - first_c, 15);

        // Same burst with the slave stalling for five cycles mid-burst.
        k = 0; p0 = r_pops;
        for (int c = 0; c < 50; c++) begin
            step(1'b0, '0, 1'b1, k < 16, mk_r(k), !(c >= 4 && c < 9), wt, rt);
            if (rt) k++;
            if (c == 8) chk("bp_ready_low", master_r_ready, 0);
        end
        chk("bp_beats", r_pops - p0, 16);

        // Random valid/ready on W and R against the model.
        for (int c = 0; c < 10000; c++) begin
            rnd = {$urandom, $urandom, $urandom};
            step($urandom_range(0, 3) != 0, rnd[82:0], $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) != 0, rnd[95:9], $urandom_range(0, 1) != 0, wt, rt);
        end
        for (int c = 0; c < 10; c++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, wt, rt);
        @(negedge clk);
        chk("rand_drained", {master_w_valid, slave_r_valid}, 2'b00);
        chk("rand_w_moved", w_pops > 1000, 1);

        // AW payload held stable under downstream stall.
        pa = {$urandom, $urandom, $urandom}; pb = ~pa; pc = pa ^ 81'h1_5555_5555_5555_5555_5555;
        master_aw_ready = 0; slave_aw_valid = 1; aw_drv = pa;
        @(negedge clk);
        chk("hold_valid", master_aw_valid, 1);
        chk("hold_a0", aw_out, pa);
        chk("hold_rdy1", slave_aw_ready, 1);
        aw_drv = pb;
        @(negedge clk);
        chk("hold_full", slave_aw_ready, 0);
        chk("hold_a1", aw_out, pa);
        aw_drv = pc;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_a2", {master_aw_valid, slave_aw_ready, aw_out}, {1'b1, 1'b0, pa});
        end
        master_aw_ready = 1;
        @(negedge clk);
        chk("hold_b", {slave_aw_ready, aw_out}, {1'b1, pb});
        @(negedge clk);
        chk("hold_c", aw_out, pc);
        slave_aw_valid = 0;
        @(negedge clk);
        chk("hold_empty", master_aw_valid, 0);

        // Fill every channel with two beats, then reset asynchronously mid-cycle.
        w_hs_in = 0; r_hs_in = 0;
        master_aw_ready = 0; master_w_ready = 0; master_ar_ready = 0; slave_b_ready = 0; slave_r_ready = 0;
        slave_aw_valid = 1; slave_w_valid = 1; slave_ar_valid = 1; master_b_valid = 1; master_r_valid = 1;
        repeat (2) @(negedge clk);
        chk("full_readies", {slave_aw_ready, slave_w_ready, slave_ar_ready, master_b_ready, master_r_ready}, 5'h0);
        chk("full_valids", {master_aw_valid, master_w_valid, master_ar_valid, slave_b_valid, slave_r_valid}, 5'h1F);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valids", {master_aw_valid, master_w_valid, master_ar_valid, slave_b_valid, slave_r_valid}, 5'h0);
        chk("async_readies", {slave_aw_ready, slave_w_ready, slave_ar_ready, master_b_ready, master_r_ready}, 5'h1F);
        slave_aw_valid = 0; slave_w_valid = 0; slave_ar_valid = 0; master_b_valid = 0; master_r_valid = 0;
        master_aw_ready = 1; master_w_ready = 1; master_ar_ready = 1; slave_b_ready = 1; slave_r_ready = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_valids", {master_aw_valid, master_w_valid, master_ar_valid, slave_b_valid, slave_r_valid}, 5'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
